// File: rtl/bp_pkg.sv
// ============================================================================
//  Module   : bp_pkg
//  Purpose  : Shared entry type and slice/constant helpers for branch_predictor
//  Revision : 1.0
// ============================================================================
`default_nettype none

package bp_pkg;

    // Fields are sized for the widest supported configuration (XLEN <= 64,
    // CTR_W <= 8); the instantiating block uses only the low bits it needs.
    localparam int unsigned BP_MAX_XLEN  = 64;
    localparam int unsigned BP_MAX_CTR_W = 8;

    typedef struct packed {
        logic                    valid;
        logic [BP_MAX_XLEN-1:0]  tag;
        logic [BP_MAX_XLEN-1:0]  target;
        logic [BP_MAX_CTR_W-1:0] ctr;
    } bp_entry_t;

    function automatic logic [BP_MAX_CTR_W-1:0] CTR_MAX(input int unsigned w);
        return BP_MAX_CTR_W'((BP_MAX_XLEN'(1) << w) - BP_MAX_XLEN'(1));
    endfunction

    function automatic logic [BP_MAX_CTR_W-1:0] CTR_WEAK_T(input int unsigned w);
        return BP_MAX_CTR_W'(BP_MAX_XLEN'(1) << (w - 1));
    endfunction

    function automatic logic [BP_MAX_XLEN-1:0] bp_index(input logic [BP_MAX_XLEN-1:0] pc,
                                                        input int unsigned            index_w);
        return (pc >> 2) & ((BP_MAX_XLEN'(1) << index_w) - BP_MAX_XLEN'(1));
    endfunction

    function automatic logic [BP_MAX_XLEN-1:0] bp_tag(input logic [BP_MAX_XLEN-1:0] pc,
                                                      input int unsigned            index_w);
        return pc >> (index_w + 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bp_sat_ctr.sv
// ============================================================================
//  Module   : bp_sat_ctr
//  Purpose  : Saturating up/down next-value function (no state)
//  Revision : 1.0
// ============================================================================
`default_nettype none

module bp_sat_ctr #(
    parameter int unsigned WIDTH = 2
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_next
);

    always_comb begin
        o_next = i_value;
        if (i_inc && !i_dec && (i_value != '1)) begin
            o_next = i_value + WIDTH'(1);
        end else if (i_dec && !i_inc && (i_value != '0)) begin
            o_next = i_value - WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================================
//  Module   : branch_predictor
//  Purpose  : Direct-mapped BTB with saturating direction counters, EX-stage
//             mispredict detection and saturating performance counters
//  Revision : 1.0
// ============================================================================
`default_nettype none

module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned CTR_W   = 2,
    parameter int unsigned PERF_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   if_pc,
    output logic              pred_taken,
    output logic [XLEN-1:0]   pred_target,
    input  logic              ex_update,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic              ex_is_cond,
    input  logic              ex_taken,
    input  logic [XLEN-1:0]   ex_target,
    input  logic              ex_pred_taken,
    input  logic [XLEN-1:0]   ex_pred_target,
    output logic              mispredict,
    output logic [XLEN-1:0]   redirect_pc,
    input  logic              flush_tables,
    output logic [PERF_W-1:0] perf_branches,
    output logic [PERF_W-1:0] perf_mispredicts
);

    localparam int unsigned INDEX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W   = XLEN - INDEX_W - 2;

    localparam logic [CTR_W-1:0] c_ctr_max  = CTR_W'(CTR_MAX(CTR_W));
    localparam logic [CTR_W-1:0] c_ctr_weak = CTR_W'(CTR_WEAK_T(CTR_W));

    bp_entry_t r_table [ENTRIES];

    logic [PERF_W-1:0] r_perf_branches;
    logic [PERF_W-1:0] r_perf_mispredicts;
    logic [PERF_W-1:0] w_perf_branches_next;
    logic [PERF_W-1:0] w_perf_mispredicts_next;

    logic [INDEX_W-1:0] w_if_idx;
    logic [TAG_W-1:0]   w_if_tag;
    logic               w_if_hit;
    logic [INDEX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0]   w_ex_tag;
    logic               w_ex_hit;
    logic [CTR_W-1:0]   w_ex_ctr;
    logic [CTR_W-1:0]   w_ex_ctr_next;
    logic               w_wr_en;
    bp_entry_t          w_new_entry;

    // Fetch-side lookup
    assign w_if_idx = INDEX_W'(bp_index(BP_MAX_XLEN'(if_pc), INDEX_W));
    assign w_if_tag = TAG_W'(bp_tag(BP_MAX_XLEN'(if_pc), INDEX_W));
    assign w_if_hit = r_table[w_if_idx].valid &&
                      (r_table[w_if_idx].tag[TAG_W-1:0] == w_if_tag);

    assign pred_taken  = w_if_hit && r_table[w_if_idx].ctr[CTR_W-1];
    assign pred_target = pred_taken ? {r_table[w_if_idx].target[XLEN-3:0], 2'b00}
                                    : if_pc + XLEN'(4);

    // Execute-side resolution
    assign w_ex_idx = INDEX_W'(bp_index(BP_MAX_XLEN'(ex_pc), INDEX_W));
    assign w_ex_tag = TAG_W'(bp_tag(BP_MAX_XLEN'(ex_pc), INDEX_W));
    assign w_ex_hit = r_table[w_ex_idx].valid &&
                      (r_table[w_ex_idx].tag[TAG_W-1:0] == w_ex_tag);
    assign w_ex_ctr = r_table[w_ex_idx].ctr[CTR_W-1:0];

    assign mispredict  = ex_update &&
                         ((ex_taken != ex_pred_taken) ||
                          (ex_taken && (ex_target != ex_pred_target)));
    assign redirect_pc = ex_taken ? ex_target : ex_pc + XLEN'(4);

    bp_sat_ctr #(
        .WIDTH (CTR_W)
    ) u_dir_ctr (
        .i_value (w_ex_ctr),
        .i_inc   (ex_taken),
        .i_dec   (!ex_taken),
        .o_next  (w_ex_ctr_next)
    );

    // A hit keeps its stored target unless the branch was taken; a miss only
    // allocates on a taken resolution.
    always_comb begin
        w_wr_en                       = 1'b0;
        w_new_entry                   = '0;
        w_new_entry.valid             = 1'b1;
        w_new_entry.tag[TAG_W-1:0]    = w_ex_tag;
        w_new_entry.target[XLEN-3:0]  = r_table[w_ex_idx].target[XLEN-3:0];
        w_new_entry.ctr[CTR_W-1:0]    = w_ex_ctr_next;
        if (ex_update) begin
            if (w_ex_hit) begin
                w_wr_en = 1'b1;
                if (ex_taken) begin
                    w_new_entry.target[XLEN-3:0] = ex_target[XLEN-1:2];
                end
                if (!ex_is_cond) begin
                    w_new_entry.ctr[CTR_W-1:0] = c_ctr_max;
                end
            end else if (ex_taken) begin
                w_wr_en                      = 1'b1;
                w_new_entry.target[XLEN-3:0] = ex_target[XLEN-1:2];
                w_new_entry.ctr[CTR_W-1:0]   = ex_is_cond ? c_ctr_weak : c_ctr_max;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                r_table[i] <= '0;
            end
        end else if (flush_tables) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                r_table[i].valid <= 1'b0;
            end
        end else if (w_wr_en) begin
            r_table[w_ex_idx] <= w_new_entry;
        end
    end

    bp_sat_ctr #(
        .WIDTH (PERF_W)
    ) u_perf_branches (
        .i_value (r_perf_branches),
        .i_inc   (ex_update),
        .i_dec   (1'b0),
        .o_next  (w_perf_branches_next)
    );

    bp_sat_ctr #(
        .WIDTH (PERF_W)
    ) u_perf_mispredicts (
        .i_value (r_perf_mispredicts),
        .i_inc   (mispredict),
        .i_dec   (1'b0),
        .o_next  (w_perf_mispredicts_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_branches    <= '0;
            r_perf_mispredicts <= '0;
        end else begin
            r_perf_branches    <= w_perf_branches_next;
            r_perf_mispredicts <= w_perf_mispredicts_next;
        end
    end

    assign perf_branches    = r_perf_branches;
    assign perf_mispredicts = r_perf_mispredicts;

endmodule

`default_nettype wire
